// File: rtl/fdiv_seq_pkg.sv
// Shared definitions for the 16-bit machine float (1/8/7, bias 127) used by
// the ALU-stage arithmetic units: widths, field accessors, constants, FSM encoding.
package fdiv_seq_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 7;
    localparam int FP_BIAS   = 2 ** (FP_EXP_W - 1) - 1;
    localparam int FP_W      = 1 + FP_EXP_W + FP_FRAC_W;

    typedef logic [FP_W-1:0] fp_t;

    localparam fp_t FZERO   = '0;
    localparam fp_t FMAXMAG = {1'b0, {(FP_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic fp_sign(input fp_t x);
        return x[FP_W-1];
    endfunction

    function automatic logic [FP_EXP_W-1:0] fp_exp(input fp_t x);
        return x[FP_W-2:FP_FRAC_W];
    endfunction

    function automatic logic [FP_FRAC_W-1:0] fp_frac(input fp_t x);
        return x[FP_FRAC_W-1:0];
    endfunction

endpackage

// File: rtl/fdiv_mant_step.sv
// One restoring-division step: conditional subtract of the divisor mantissa,
// yielding the quotient bit and the left-shifted partial remainder.
module fdiv_mant_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] d,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W-1:0] diff;

    assign q_bit = (rem >= d);
    assign diff  = rem - d;
    // The remainder entering a step is always < 2*d, so the shifted result fits in W bits.
    assign rem_next = q_bit ? {diff[W-2:0], 1'b0} : {rem[W-2:0], 1'b0};

endmodule

// File: rtl/fdiv_seq.sv
// Iterative floating-point divider r = a / b with truncated quotient,
// saturation on overflow and flush-to-zero on underflow.
module fdiv_seq #(
    parameter int EXP_W  = fdiv_seq_pkg::FP_EXP_W,
    parameter int FRAC_W = fdiv_seq_pkg::FP_FRAC_W,
    parameter int BIAS   = 2 ** (EXP_W - 1) - 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     a,
    input  logic [EXP_W+FRAC_W:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     r,
    output logic                      dz,
    output logic                      ovf,
    output logic                      unf
);
    import fdiv_seq_pkg::*;

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(FRAC_W + 3);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_MIN = EW'(1);

    state_t state_reg, state_next;

    logic [MW-1:0]        rem_reg, d_reg, q_reg, rem_step;
    logic [CW-1:0]        cnt_reg;
    logic signed [EW-1:0] e_reg, e_init, e_norm;
    logic                 sign_reg, q_bit;
    logic [W-1:0]         r_reg;
    logic                 dz_reg, ovf_reg, unf_reg;
    logic [FRAC_W-1:0]    frac_norm;
    logic                 ovf_norm, unf_norm;

    logic                 s_in, a_zero, b_zero;
    logic [EXP_W-1:0]     a_exp, b_exp;
    logic [FRAC_W-1:0]    a_frac, b_frac;

    assign a_exp  = a[W-2:FRAC_W];
    assign b_exp  = b[W-2:FRAC_W];
    assign a_frac = a[FRAC_W-1:0];
    assign b_frac = b[FRAC_W-1:0];
    assign s_in   = a[W-1] ^ b[W-1];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign e_init = EW'(a_exp) - EW'(b_exp) + EW'(BIAS);

    fdiv_mant_step #(.W(MW)) u_step (
        .rem      (rem_reg),
        .d        (d_reg),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    // A quotient below 1.0 leaves the top bit clear and costs one exponent step.
    assign e_norm    = q_reg[MW-1] ? e_reg : e_reg - EW'(1);
    assign frac_norm = q_reg[MW-1] ? q_reg[FRAC_W:1] : q_reg[FRAC_W-1:0];
    assign ovf_norm  = (e_norm > E_MAX);
    assign unf_norm  = (e_norm < E_MIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = (a_zero || b_zero) ? DONE : DIV;
            DIV:  if (cnt_reg == CW'(1)) state_next = NORM;
            NORM: state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg  <= '0;
            d_reg    <= '0;
            q_reg    <= '0;
            cnt_reg  <= '0;
            e_reg    <= '0;
            sign_reg <= 1'b0;
            r_reg    <= '0;
            dz_reg   <= 1'b0;
            ovf_reg  <= 1'b0;
            unf_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    sign_reg <= s_in;
                    dz_reg   <= 1'b0;
                    ovf_reg  <= 1'b0;
                    unf_reg  <= 1'b0;
                    if (b_zero) begin
                        r_reg  <= {s_in, {(W-1){1'b1}}};
                        dz_reg <= 1'b1;
                    end else if (a_zero) begin
                        r_reg <= '0;
                    end else begin
                        rem_reg <= {1'b0, 1'b1, a_frac};
                        d_reg   <= {1'b0, 1'b1, b_frac};
                        q_reg   <= '0;
                        cnt_reg <= CW'(FRAC_W + 2);
                        e_reg   <= e_init;
                    end
                end
                DIV: begin
                    rem_reg <= rem_step;
                    q_reg   <= {q_reg[MW-2:0], q_bit};
                    cnt_reg <= cnt_reg - CW'(1);
                end
                NORM: begin
                    if (ovf_norm) begin
                        r_reg   <= {sign_reg, {(W-1){1'b1}}};
                        ovf_reg <= 1'b1;
                    end else if (unf_norm) begin
                        r_reg   <= {sign_reg, {(W-1){1'b0}}};
                        unf_reg <= 1'b1;
                    end else begin
                        r_reg <= {sign_reg, e_norm[EXP_W-1:0], frac_norm};
                    end
                end
                default: ;
            endcase
        end
    end

    assign r   = r_reg;
    assign dz  = dz_reg;
    assign ovf = ovf_reg;
    assign unf = unf_reg;

endmodule
